// File: rtl/ex1_pkg.sv
// Shared constants for the ex1 one-hot ring sequencer.
// State encodings are kept as plain vectors so the register maps straight onto A..D.
package ex1_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] S0 = 4'b1000;
  localparam logic [STATE_W-1:0] S1 = 4'b0100;
  localparam logic [STATE_W-1:0] S2 = 4'b0010;
  localparam logic [STATE_W-1:0] S3 = 4'b0001;

endpackage

// File: rtl/ex1_fsm.sv
// Bidirectional 4-state one-hot ring sequencer (Moore).
// Y=1 rotates ABCD right, Y=0 rotates it left; any non-one-hot value snaps back to S0.
module ex1_fsm
  import ex1_pkg::*;
(
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  input  logic Y,
  input  logic reset,
  input  logic clk
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;

  always_comb begin
    state_nxt = S0;
    case (state)
      S0:      state_nxt = Y ? S1 : S3;
      S1:      state_nxt = Y ? S2 : S0;
      S2:      state_nxt = Y ? S3 : S1;
      S3:      state_nxt = Y ? S0 : S2;
      // Zero or multiple bits set: recover to S0 in a single edge, ignoring Y.
      default: state_nxt = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  assign {A, B, C, D} = state;

endmodule

// File: tb/tb_ex1_fsm.sv
// Directed bench for ex1_fsm: literal per-step expectations plus a ring-position
// model compared against the outputs on every cycle after the first reset.
module tb_ex1_fsm;

  logic clk;
  logic reset;
  logic Y;
  logic A, B, C, D;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: position on the ring (0..3 from the MSB) or an injected illegal pattern.
  logic [3:0] m_state;
  logic       m_valid = 1'b0;
  logic       inj_pending = 1'b0;
  logic [3:0] inj_pat = 4'b0000;

  ex1_fsm dut (
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .Y     (Y),
    .reset (reset),
    .clk   (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: ABCD got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one step per edge, computed from ring position arithmetic.
  always @(posedge clk) begin
    logic [3:0] cur;
    int pos;
    cur = inj_pending ? inj_pat : m_state;
    if (reset === 1'b0) begin
      m_state <= 4'b1000;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if ($countones(cur) != 1) begin
        m_state <= 4'b1000;
      end else begin
        pos = 0;
        for (int i = 0; i < 4; i++) if (cur[3-i]) pos = i;
        pos = (Y === 1'b1) ? (pos + 1) % 4 : (pos + 3) % 4;
        m_state <= 4'b1000 >> pos;
      end
    end
  end

  // Compare process: outputs against model every cycle once the model is valid.
  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      check("model", {A, B, C, D}, m_state);
      if ($countones(m_state) == 1) begin
        n_checks++;
        if (!$onehot({A, B, C, D})) begin
          n_fail++;
          $display("FAIL onehot: ABCD got %b, expected exactly one bit set", {A, B, C, D});
        end
      end
    end
  end

  task automatic step(input logic y, input logic r, input logic [3:0] exp, input string name);
    @(negedge clk);
    Y = y;
    reset = r;
    @(posedge clk);
    #1;
    check(name, {A, B, C, D}, exp);
  endtask

  task automatic inject(input logic [3:0] pat, input logic y, input string name);
    @(negedge clk);
    Y = y;
    reset = 1'b1;
    inj_pat = pat;
    inj_pending = 1'b1;
    force dut.state = pat;
    #1;
    release dut.state;
    #1;
    check({name, "_held"}, {A, B, C, D}, pat);
    @(posedge clk);
    #1;
    inj_pending = 1'b0;
    check({name, "_recover"}, {A, B, C, D}, 4'b1000);
  endtask

  initial begin
    reset = 1'b0;
    Y = 1'b1;
    @(posedge clk);
    #1;
    check("reset", {A, B, C, D}, 4'b1000);

    // Forward walk with D->A wrap.
    step(1'b1, 1'b1, 4'b0100, "fwd1");
    step(1'b1, 1'b1, 4'b0010, "fwd2");
    step(1'b1, 1'b1, 4'b0001, "fwd3");
    step(1'b1, 1'b1, 4'b1000, "fwd_wrap");
    step(1'b1, 1'b1, 4'b0100, "fwd5");
    step(1'b1, 1'b1, 4'b0010, "fwd6");

    // Backward walk with A->D wrap.
    step(1'b0, 1'b1, 4'b0100, "bwd1");
    step(1'b0, 1'b1, 4'b1000, "bwd2");
    step(1'b0, 1'b1, 4'b0001, "bwd_wrap");

    // Direction reversal from S3.
    step(1'b1, 1'b1, 4'b1000, "rev1");
    step(1'b1, 1'b1, 4'b0100, "rev2");
    step(1'b1, 1'b1, 4'b0010, "rev3");

    // Reset priority mid-sequence.
    step(1'b1, 1'b1, 4'b0001, "pre_rst");
    step(1'b1, 1'b0, 4'b1000, "rst_from_s3");
    step(1'b1, 1'b1, 4'b0100, "resume_fwd");
    step(1'b1, 1'b0, 4'b1000, "rst_from_s1");
    step(1'b0, 1'b1, 4'b0001, "resume_bwd");

    // Illegal-state recovery.
    inject(4'b0000, 1'b0, "ill_zero_y0");
    inject(4'b0000, 1'b1, "ill_zero_y1");
    inject(4'b1100, 1'b0, "ill_two_y0");
    inject(4'b1100, 1'b1, "ill_two_y1");

    step(1'b1, 1'b1, 4'b0100, "post_ill1");
    step(1'b0, 1'b1, 4'b1000, "post_ill2");
    step(1'b0, 1'b1, 4'b0001, "post_ill3");

    repeat (2) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
